// File: rtl/xor_share_arbiter.sv
// Round-robin arbiter sharing one XOR datapath among N requesters.
// The single result register is tagged with the requester index and held until consumed.
//
// state | meaning
// EMPTY | result register holds nothing; r_valid=0
// FULL  | result register holds an unconsumed result; r_valid=1
module xor_share_arbiter #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  a,
  input  logic [N*W-1:0]  b,
  output logic [N-1:0]    gnt,
  output logic            r_valid,
  output logic [W-1:0]    r_data,
  output logic [IW-1:0]   r_id,
  input  logic            r_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic            acc;
  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW:0]     cand;
  logic            grant;
  logic [W-1:0]    xor_sel;
  logic [IW-1:0]   ptr_next;

  assign r_valid = (state == FULL);
  assign acc     = ~r_valid | r_ready;

  // Cyclic search starting at ptr; the extra index bit absorbs ptr+j before the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int j = 0; j < N; j++) begin
      cand = {1'b0, ptr} + (IW+1)'(j);
      if (cand >= (IW+1)'(N))
        cand = cand - (IW+1)'(N);
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
  end

  assign grant = rst_n & acc & win_found;

  always_comb begin
    gnt = '0;
    if (grant)
      gnt = N'(1) << win_idx;
  end

  always_comb begin
    xor_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == win_idx)
        xor_sel = a[i*W +: W] ^ b[i*W +: W];
    end
  end

  assign ptr_next = (win_idx == IW'(N-1)) ? '0 : win_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= EMPTY;
      r_data <= '0;
      r_id   <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (grant) begin
            state  <= FULL;
            r_data <= xor_sel;
            r_id   <= win_idx;
            ptr    <= ptr_next;
          end
        end
        FULL: begin
          // A drain and a new grant in the same cycle overwrite without a bubble.
          if (grant) begin
            r_data <= xor_sel;
            r_id   <= win_idx;
            ptr    <= ptr_next;
          end else if (r_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_share_arbiter.sv
// Directed testbench for xor_share_arbiter (N=4, W=8) with hand-computed expectations.
module tb_xor_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  a;
  logic [N*W-1:0]  b;
  logic [N-1:0]    gnt;
  logic            r_valid;
  logic [W-1:0]    r_data;
  logic [IW-1:0]   r_id;
  logic            r_ready;

  int n_cmp;
  int n_bad;

  xor_share_arbiter #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a       (a),
    .b       (b),
    .gnt     (gnt),
    .r_valid (r_valid),
    .r_data  (r_data),
    .r_id    (r_id),
    .r_ready (r_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; registered outputs are then sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    check({tag, ".r_valid"}, 32'(r_valid), 32'(v));
    check({tag, ".r_data"},  32'(r_data),  32'(d));
    check({tag, ".r_id"},    32'(r_id),    32'(id));
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    req     = 4'b1111;
    a       = '0;
    b       = '0;
    r_ready = 1'b1;

    // Reset: gnt held low even with requests pending
    settle();
    check("rst.gnt", 32'(gnt), 32'h0);
    tick();
    tick();
    check("rst.gnt2", 32'(gnt), 32'h0);
    check_out("rst", 1'b0, 8'h00, 2'd0);

    rst_n = 1'b1;
    req   = '0;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("idle.gnt", 32'(gnt), 32'h0);
      tick();
      check_out("idle", 1'b0, 8'h00, 2'd0);
    end

    // Single operation on requester 2
    req       = 4'b0100;
    a[2*W +: W] = 8'hA5;
    b[2*W +: W] = 8'h3C;
    settle();
    check("single.gnt", 32'(gnt), 32'h4);
    tick();
    req = '0;
    check_out("single", 1'b1, 8'h99, 2'd2);
    settle();
    check("single.gnt_off", 32'(gnt), 32'h0);

    // Reset again so round-robin starts from ptr=0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_out("rst2", 1'b0, 8'h00, 2'd0);

    req = 4'b1111;
    for (int i = 0; i < N; i++) begin
      a[i*W +: W] = 8'(i);
      b[i*W +: W] = 8'hF0;
    end
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr.gnt", 32'(gnt), 32'(4'b0001 << (k % 4)));
      tick();
      check_out("rr", 1'b1, 8'hF0 | 8'(k % 4), 2'(k % 4));
    end
    // ptr now 1; holding result F0 from requester 0

    // Backpressure: frozen while full and not ready
    r_ready = 1'b0;
    req     = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      settle();
      check("bp.gnt", 32'(gnt), 32'h0);
      tick();
      check_out("bp", 1'b1, 8'hF0, 2'd0);
    end
    r_ready = 1'b1;
    settle();
    check("bp.release_gnt", 32'(gnt), 32'h2);
    tick();
    check_out("bp.release", 1'b1, 8'hF1, 2'd1);

    // Wrap and skip: grant 2 -> ptr 3, then req=0010 wraps to 1
    req = 4'b0100;
    a[2*W +: W] = 8'h02;
    b[2*W +: W] = 8'hF0;
    settle();
    check("wrap.g2", 32'(gnt), 32'h4);
    tick();
    check_out("wrap.g2", 1'b1, 8'hF2, 2'd2);
    req = 4'b0010;
    settle();
    check("wrap.g1", 32'(gnt), 32'h2);
    tick();
    check_out("wrap.g1", 1'b1, 8'hF1, 2'd1);
    // ptr=2: requesters 0,1 active, search 2,3,0 picks 0
    req = 4'b0011;
    settle();
    check("wrap.ptr2", 32'(gnt), 32'h1);
    tick();
    check_out("wrap.g0", 1'b1, 8'hF0, 2'd0);

    // Drain without grant keeps data and id
    req = '0;
    settle();
    check("drain.gnt", 32'(gnt), 32'h0);
    tick();
    check_out("drain", 1'b0, 8'hF0, 2'd0);

    // Mid-operation reset: grant 2 (ptr->3), stall, then reset
    req = 4'b0100;
    settle();
    check("mid.g2", 32'(gnt), 32'h4);
    tick();
    check_out("mid.g2", 1'b1, 8'hF2, 2'd2);
    r_ready = 1'b0;
    req     = 4'b1100;
    settle();
    check("mid.stall_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b0;
    r_ready = 1'b1;
    settle();
    check("mid.rst_gnt", 32'(gnt), 32'h0);
    tick();
    rst_n = 1'b1;
    check_out("mid.rst", 1'b0, 8'h00, 2'd0);
    a[3*W +: W] = 8'h03;
    b[3*W +: W] = 8'hF0;
    settle();
    check("mid.first_gnt", 32'(gnt), 32'h4);
    tick();
    check_out("mid.first", 1'b1, 8'hF2, 2'd2);
    settle();
    check("mid.next_gnt", 32'(gnt), 32'h8);
    tick();
    check_out("mid.next", 1'b1, 8'hF3, 2'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
